seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumes the 16-bit packed BCD score produced by the binary-to-BCD converter.
- Time-multiplexes it onto a 4-digit common-anode 7-segment display.
- Latches the BCD value only at frame boundaries so digits never tear mid-scan.
- Adds leading-zero blanking, a per-digit decimal-point mask and a whole-display blink used for game-over indication.

Parameters:
- DIGIT_CYCLES, 100000, clk cycles each digit is driven (1 kHz digit rate at 100 MHz); must be >= 2.
- BLINK_FRAMES, 125, full 4-digit frames per blink half-period (0.5 s at defaults); must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- BCD  in  16  packed BCD; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- blank_lz  in  1  1 = suppress leading zeros.
- blink_en  in  1  1 = blink entire display.
- dp_mask  in  4  bit k = 1 lights the decimal point of digit k (0 = units).
- an  out  4  anode enables, active-low; bit k drives digit k.
- seg  out  7  cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal-point cathode, active-low.
- frame_tick  out  1  one-cycle pulse when a new frame (digit 0) begins.

Behaviour:
- Reset (async assert, applied immediately):
  - prescaler=0, digit_sel=0, shadow=16'h0000, blink_cnt=0, blink_phase=0.
  - an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
- Prescaler:
  - Counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - Its terminal count (TC) is the cycle in which prescaler==DIGIT_CYCLES-1.
- Digit select: on TC, digit_sel advances 0->1->2->3->0 (2-bit wrap).
- Frame boundary (TC while digit_sel==3):
  - shadow <= BCD.
  - frame_tick=1 on the following cycle, coincident with digit_sel becoming 0.
  - BCD is sampled only here; changes between boundaries are ignored.
- First frame after reset displays shadow=0, i.e. "0" or "0000" per blank_lz.
- Outputs are registered, 1-cycle latency:
  - an/seg/dp reflect digit_sel and shadow as of the previous cycle.
  - an is one-hot low (digit k active => an[k]=0, others 1).
- Decode, nibble -> seg (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 (invalid BCD) = 0111111 (dash, g only).
- Leading-zero blanking:
  - Applies when blank_lz=1.
  - Digit k (k=3,2,1) is blank when every nibble from 3 down to k is 0.
  - Digit 0 is never blanked.
  - Blanked digit: seg=7'b1111111, an still asserted.
  - dp follows dp_mask regardless of blanking.
- dp = ~dp_mask[digit_sel].
- Blink:
  - blink_cnt increments at each frame boundary; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - Counting continues whether or not blink_en is set.
  - When blink_en=1 and blink_phase=1: an=4'b1111 (seg/dp don't-care, driven per decode).
  - blink_en=0 shows the display immediately on the next cycle.
- Simultaneous events:
  - A BCD change on the boundary cycle itself is captured.
  - blank_lz, blink_en and dp_mask are used combinationally into the output register each cycle, not shadowed.
- Reset mid-frame: everything returns to reset values at once; scanning resumes from digit 0, prescaler 0, after reset deasserts.

Test Plan (DIGIT_CYCLES=4, BLINK_FRAMES=2):
- Reset held, then released with BCD=16'h1234:
  - During reset, an=1111, seg=1111111, dp=1.
  - First frame shows 0000 (shadow), with frame_tick pulsing every 16 cycles.
  - Second frame onward, digit0 seg=0011001 ('4'), then digit1 '3'=0110000, digit2 '2'=0100100, digit3 '1'=1111001, each lasting 4 cycles with an = 1110, 1101, 1011, 0111.
- Leading-zero blanking, BCD=16'h0007, blank_lz=1:
  - Digits 3..1 have seg=1111111 with their anodes still low.
  - Digit0 seg=1111000.
  - BCD=16'h0000 shows only digit0 '0'=1000000.
- Tearing check: change BCD from 16'h0099 to 16'h0100 while digit_sel==1:
  - Remainder of the frame still shows 0099.
  - 0100 appears only after the next frame_tick.
- Invalid nibble and decimal point, BCD=16'h00A5, dp_mask=4'b0010:
  - Digit1 seg=0111111 (dash) with dp=0.
  - All other digits have dp=1.
- Blink, blink_en=1: an is forced to 1111 for 2 frames (32 cycles), then shows digits for 2 frames, alternating.
- Async reset mid-frame:
  - Asserting reset at digit_sel=2 forces an=1111 in the same cycle, before any clk edge.
  - After release, digit 0 is driven for a full 4 cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Drives a 4-digit common-anode 7-segment display from a packed BCD score.
//   Each digit is shown for DIGIT_CYCLES clocks in turn. The BCD input is
//   copied into a shadow register only at frame boundaries, so a frame never
//   mixes digits from two different values. Optional leading-zero blanking,
//   per-digit decimal points and a whole-display blink are also provided.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   BCD        packed BCD {thousands, hundreds, tens, units}
//   blank_lz   1 = suppress leading zeros (digit 0 always shown)
//   blink_en   1 = blank all anodes during the blink "off" half-period
//   dp_mask    bit k lights the decimal point of digit k (0 = units)
//   an         anode enables, active-low, one-hot
//   seg        cathodes {g,f,e,d,c,b,a}, active-low
//   dp         decimal-point cathode, active-low
//   frame_tick one-cycle pulse as digit 0 of a new frame begins
module seg7_scan_driver #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] BCD,
  input  logic        blank_lz,
  input  logic        blink_en,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned PW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(BLINK_FRAMES - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_sel;
  logic [15:0]   shadow;
  logic [CW-1:0] blink_cnt;
  logic          blink_phase;

  logic          tc;
  logic          frame_end;
  logic [3:0]    nib;
  logic [3:0]    lz;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;  // invalid BCD: dash
    endcase
    return s;
  endfunction

  always_comb begin
    tc        = (prescaler == P_LAST);
    frame_end = tc && (digit_sel == 2'd3);

    case (digit_sel)
      2'd0:    nib = shadow[3:0];
      2'd1:    nib = shadow[7:4];
      2'd2:    nib = shadow[11:8];
      default: nib = shadow[15:12];
    endcase

    // lz[k]: every nibble from 3 down to k is zero; digit 0 never blanks
    lz[3] = (shadow[15:12] == 4'd0);
    lz[2] = lz[3] && (shadow[11:8] == 4'd0);
    lz[1] = lz[2] && (shadow[7:4] == 4'd0);
    lz[0] = 1'b0;

    an_nxt = ~(4'b0001 << digit_sel);
    if (blink_en && blink_phase)
      an_nxt = '1;

    seg_nxt = (blank_lz && lz[digit_sel]) ? '1 : decode(nib);
    dp_nxt  = ~dp_mask[digit_sel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      digit_sel   <= '0;
      shadow      <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      prescaler <= tc ? '0 : prescaler + 1'b1;

      if (tc)
        digit_sel <= digit_sel + 2'd1;

      // Frame boundary: capture the new value and advance the blink timer
      if (frame_end) begin
        shadow <= BCD;
        if (blink_cnt == C_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      frame_tick <= frame_end;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with DIGIT_CYCLES=4, BLINK_FRAMES=2.
//   Outputs are sampled on the falling clock edge; positions in comments are
//   counted in falling edges from the relevant reset release or frame_tick.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] BCD = 16'h1234;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [3:0]  dp_mask = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int total = 0;
  int bad = 0;

  seg7_scan_driver #(
    .DIGIT_CYCLES(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .BCD        (BCD),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] ea,
                           input logic [6:0] es, input logic ed);
    chk({tag, "_an"}, 16'(an), 16'(ea));
    chk({tag, "_seg"}, 16'(seg), 16'(es));
    chk({tag, "_dp"}, 16'(dp), 16'(ed));
  endtask

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next falling edge where frame_tick is high (bounded)
  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1)
        seen = 1'b1;
    end
    total++;
    assert (seen)
    else begin
      bad++;
      $error("FAIL %s observed=no_frame_tick expected=frame_tick within 64 cycles", tag);
    end
  endtask

  initial begin
    // Reset held
    go(2);
    check_out("rst", 4'b1111, 7'b1111111, 1'b1);
    chk("rst_tick", 16'(frame_tick), 16'h0);
    reset = 1'b0;

    // First frame: shadow is 0 -> "0000", digit 0 for 4 cycles
    go(1);  check_out("f0_d0_first", 4'b1110, 7'b1000000, 1'b1);
    go(3);  check_out("f0_d0_last", 4'b1110, 7'b1000000, 1'b1);
    go(1);  check_out("f0_d1", 4'b1101, 7'b1000000, 1'b1);
    go(10); chk("tick_lo_15", 16'(frame_tick), 16'h0);
    go(1);  chk("tick_hi_16", 16'(frame_tick), 16'h1);
    // Second frame shows 1234
    go(2);  check_out("f1_d0_4", 4'b1110, 7'b0011001, 1'b1);
            chk("tick_lo_18", 16'(frame_tick), 16'h0);
    go(4);  check_out("f1_d1_3", 4'b1101, 7'b0110000, 1'b1);
    go(4);  check_out("f1_d2_2", 4'b1011, 7'b0100100, 1'b1);
    go(4);  check_out("f1_d3_1", 4'b0111, 7'b1111001, 1'b1);
    go(2);  chk("tick_hi_32", 16'(frame_tick), 16'h1);

    // Leading-zero blanking with 0007
    BCD = 16'h0007;
    blank_lz = 1'b1;
    wait_tick("wt_lz7");
    go(2);  check_out("lz7_d0", 4'b1110, 7'b1111000, 1'b1);
    go(4);  check_out("lz7_d1", 4'b1101, 7'b1111111, 1'b1);
    go(4);  check_out("lz7_d2", 4'b1011, 7'b1111111, 1'b1);
    go(4);  check_out("lz7_d3", 4'b0111, 7'b1111111, 1'b1);
    BCD = 16'h0000;
    wait_tick("wt_lz0");
    go(2);  check_out("lz0_d0", 4'b1110, 7'b1000000, 1'b1);
    go(4);  check_out("lz0_d1", 4'b1101, 7'b1111111, 1'b1);

    // Tearing: load 0099, then change to 0100 while digit 1 is active
    BCD = 16'h0099;
    blank_lz = 1'b0;
    wait_tick("wt_99");
    go(6);
    BCD = 16'h0100;
    go(2);  check_out("tear_d1_9", 4'b1101, 7'b0010000, 1'b1);
    go(4);  check_out("tear_d2_0", 4'b1011, 7'b1000000, 1'b1);
    go(4);  check_out("tear_d3_0", 4'b0111, 7'b1000000, 1'b1);
            chk("tear_tick", 16'(frame_tick), 16'h1);
    go(2);  check_out("new_d0_0", 4'b1110, 7'b1000000, 1'b1);
    go(4);  check_out("new_d1_0", 4'b1101, 7'b1000000, 1'b1);
    go(4);  check_out("new_d2_1", 4'b1011, 7'b1111001, 1'b1);

    // Invalid nibble and decimal point
    BCD = 16'h00A5;
    dp_mask = 4'b0010;
    wait_tick("wt_a5");
    go(2);  check_out("a5_d0", 4'b1110, 7'b0010010, 1'b1);
    go(4);  check_out("a5_d1", 4'b1101, 7'b0111111, 1'b0);
    go(4);  check_out("a5_d2", 4'b1011, 7'b1000000, 1'b1);
    go(4);  check_out("a5_d3", 4'b0111, 7'b1000000, 1'b1);

    // Async reset while digit 2 is active
    wait_tick("wt_rst");
    go(10); check_out("pre_rst_d2", 4'b1011, 7'b1000000, 1'b1);
    #1 reset = 1'b1;
    #1 check_out("async_rst", 4'b1111, 7'b1111111, 1'b1);
    chk("async_rst_tick", 16'(frame_tick), 16'h0);
    go(2);
    reset = 1'b0;
    go(1);  check_out("rr_d0_first", 4'b1110, 7'b1000000, 1'b1);
    go(3);  check_out("rr_d0_last", 4'b1110, 7'b1000000, 1'b1);
    go(1);  check_out("rr_d1", 4'b1101, 7'b1000000, 1'b0);

    // Blink: phase turns on at the 2nd boundary after reset (edge 32),
    // off again at edge 64, on again at edge 96
    blink_en = 1'b1;
    go(1);  chk("bl_6_an", 16'(an), 16'b1101);
    go(26); chk("bl_32_an", 16'(an), 16'b0111);
    go(1);  chk("bl_33_an", 16'(an), 16'b1111);
    go(15); chk("bl_48_an", 16'(an), 16'b1111);
            chk("bl_48_tick", 16'(frame_tick), 16'h1);
    go(16); chk("bl_64_an", 16'(an), 16'b1111);
    go(1);  chk("bl_65_an", 16'(an), 16'b1110);
    go(31); chk("bl_96_an", 16'(an), 16'b0111);
    go(1);  chk("bl_97_an", 16'(an), 16'b1111);
    blink_en = 1'b0;
    go(1);  chk("bl_off_an", 16'(an), 16'b1110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
